normalizer_scaler: RTL and testbench

//  Sink end of the normalizer spectrum stream (spect_data_1/2, spect_valid, spect_rdy).
//  - Accepts sample pairs and divides each signed sample by the block-peak magnitude `max`.
//  - Writes the scaled Q1.FRAC pair back to memory through a DMA write port.
//  - Sits after normalizer_controller; its write-back region is [dst_start_addr..dst_stop_addr].

---
 rtl/normalizer_scaler_pkg.sv | 27 ++
 rtl/normalizer_scaler_div.sv | 55 +++++
 rtl/normalizer_scaler.sv | 140 ++++++++++++++
 tb/tb_normalizer_scaler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/normalizer_scaler_pkg.sv
// Shared types and helpers for the normalizer scaler: FSM state encoding,
// default fraction width, and the lane-level magnitude/saturation helpers.
package normalizer_scaler_pkg;

  localparam int NORM_FRAC = 15;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_DIV    = 3'd2,
    S_FINAL  = 3'd3,
    S_WRITE  = 3'd4,
    S_WAIT   = 3'd5
  } state_t;

  // Magnitude of a signed 16-bit sample; 0x8000 stays 0x8000 as an unsigned value.
  function automatic logic [15:0] abs16(input logic [15:0] x);
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  function automatic logic [15:0] sat_sign(input logic [31:0] mag, input logic neg);
    logic [15:0] m;
    m = (mag > 32'h0000_7FFF) ? 16'h7FFF : mag[15:0];
    return neg ? (~m + 16'd1) : m;
  endfunction

endpackage

// File: rtl/normalizer_scaler_div.sv
// normalizer_div: restoring unsigned divider, one quotient bit per cycle, MSB first.
// done is high on the cycle after the last iteration.
module normalizer_div #(
  parameter int DIV_W = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [15:0]      divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [15:0]      remainder,
  output logic             done
);

  localparam int CW = $clog2(DIV_W + 1);

  logic [CW-1:0] cnt;
  logic [15:0]   dvs;
  logic [16:0]   partial;
  logic          ge;
  logic [15:0]   diff;

  // quotient doubles as the dividend shift register: bits leave at the top
  // and quotient bits enter at the bottom.
  always_comb begin
    partial = {remainder, quotient[DIV_W-1]};
    ge      = (partial >= {1'b0, dvs});
    diff    = partial[15:0] - dvs;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
      done      <= 1'b0;
    end else if (start) begin
      cnt       <= CW'(DIV_W);
      dvs       <= divisor;
      quotient  <= dividend;
      remainder <= '0;
      done      <= 1'b0;
    end else if (cnt != '0) begin
      cnt       <= cnt - 1'b1;
      quotient  <= {quotient[DIV_W-2:0], ge};
      remainder <= ge ? diff : partial[15:0];
      done      <= (cnt == CW'(1));
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/normalizer_scaler.sv
// Spectrum sink: divides each sample pair by the block peak and DMA-writes the
// saturated Q1.FRAC result. Define NORM_ROUND_EN for round-half-up, else truncate.
module normalizer_scaler
  import normalizer_scaler_pkg::*;
#(
  parameter int FRAC  = NORM_FRAC,
  parameter int DIV_W = 16 + FRAC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dst_start_addr,
  input  logic [31:0] dst_stop_addr,
  input  logic [15:0] max,
  input  logic [15:0] spect_data_1,
  input  logic [15:0] spect_data_2,
  input  logic        spect_valid,
  output logic        spect_rdy,
  output logic [31:0] dma_addr,
  output logic        dma_write,
  output logic [31:0] dma_writedata,
  input  logic        dma_rdy,
  output logic        busy,
  output logic        done,
  output state_t      state_dbg
);

  localparam int CW = $clog2(DIV_W + 1);

  // Handshakes: a pair transfers on any cycle with spect_valid && spect_rdy;
  // a write is a one-cycle dma_write and completes on a dma_rdy seen in WAIT.
  state_t          state;
  logic [31:0]     f_addr, stop_addr;
  logic            neg1, neg2, zero_max;
  logic [15:0]     max_q;
  logic [CW-1:0]   div_cnt;
  logic            div_start, d1_done, d2_done;
  logic [DIV_W-1:0] q1, q2;
  logic [15:0]     rem1, rem2;
  logic            rnd1, rnd2;
  logic [31:0]     mag1, mag2;

  assign spect_rdy = (state == S_ACCEPT) && spect_valid;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
  assign div_start = spect_rdy && (max != 16'd0);

  normalizer_div #(.DIV_W(DIV_W)) u_div1 (
    .clk(clk), .rst(rst), .start(div_start),
    .dividend({abs16(spect_data_1), {FRAC{1'b0}}}), .divisor(max),
    .quotient(q1), .remainder(rem1), .done(d1_done)
  );

  normalizer_div #(.DIV_W(DIV_W)) u_div2 (
    .clk(clk), .rst(rst), .start(div_start),
    .dividend({abs16(spect_data_2), {FRAC{1'b0}}}), .divisor(max),
    .quotient(q2), .remainder(rem2), .done(d2_done)
  );

`ifdef NORM_ROUND_EN
  assign rnd1 = ({rem1, 1'b0} >= {1'b0, max_q});
  assign rnd2 = ({rem2, 1'b0} >= {1'b0, max_q});
`else
  logic unused_rem;
  assign unused_rem = ^{rem1, rem2, max_q};
  assign rnd1 = 1'b0;
  assign rnd2 = 1'b0;
`endif

  assign mag1 = zero_max ? 32'd0 : 32'(q1) + 32'(rnd1);
  assign mag2 = zero_max ? 32'd0 : 32'(q2) + 32'(rnd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      f_addr        <= '0;
      stop_addr     <= '0;
      neg1          <= 1'b0;
      neg2          <= 1'b0;
      zero_max      <= 1'b0;
      max_q         <= '0;
      div_cnt       <= '0;
      dma_addr      <= '0;
      dma_write     <= 1'b0;
      dma_writedata <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            f_addr    <= dst_start_addr;
            stop_addr <= dst_stop_addr;
            state     <= S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (spect_valid) begin
            neg1     <= spect_data_1[15];
            neg2     <= spect_data_2[15];
            max_q    <= max;
            zero_max <= (max == 16'd0);
            div_cnt  <= '0;
            state    <= S_DIV;
          end
        end
        S_DIV: begin
          if (zero_max || div_cnt == CW'(DIV_W - 1)) state <= S_FINAL;
          else div_cnt <= div_cnt + 1'b1;
        end
        S_FINAL: begin
          if ((d1_done && d2_done) || zero_max)
            dma_writedata <= {sat_sign(mag1, neg1), sat_sign(mag2, neg2)};
          dma_addr  <= f_addr;
          dma_write <= 1'b1;
          state     <= S_WRITE;
        end
        S_WRITE: begin
          dma_addr      <= '0;
          dma_write     <= 1'b0;
          dma_writedata <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (dma_rdy) begin
            if (f_addr == stop_addr) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              f_addr <= f_addr + 32'd4;
              state  <= S_ACCEPT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalizer_scaler.sv
// Bench for normalizer_scaler: table vectors, hand sequences and random blocks
// scored against an arithmetic model of the scaling rule.
module tb_normalizer_scaler;
  import normalizer_scaler_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dst_start_addr = '0, dst_stop_addr = '0;
  logic [15:0] max = '0, spect_data_1 = '0, spect_data_2 = '0;
  logic        spect_valid = 1'b0;
  logic        spect_rdy;
  logic [31:0] dma_addr, dma_writedata;
  logic        dma_write;
  logic        dma_rdy = 1'b0;
  logic        busy, done;
  state_t      state_dbg;

  int errors = 0, checks = 0;
  int n_rdy = 0, n_done = 0, n_writes = 0, rdy_delay = 1;
  logic [63:0] exp_q[$];
  logic [15:0] bx1[8], bx2[8], bmx[8];
  logic [31:0] bexp[8];

  typedef struct {
    logic [15:0] x1, x2, mx;
    logic [31:0] exp;
  } vec_t;
  vec_t tab[6];

  normalizer_scaler dut (
    .clk(clk), .rst(rst), .start(start),
    .dst_start_addr(dst_start_addr), .dst_stop_addr(dst_stop_addr),
    .max(max), .spect_data_1(spect_data_1), .spect_data_2(spect_data_2),
    .spect_valid(spect_valid), .spect_rdy(spect_rdy),
    .dma_addr(dma_addr), .dma_write(dma_write), .dma_writedata(dma_writedata),
    .dma_rdy(dma_rdy), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: magnitude * 2^15 / max, optional round half up, saturate, re-sign.
  function automatic logic [15:0] model_lane(input logic [15:0] x, input logic [15:0] m);
    longint mag, num, q;
    if (m == 16'd0) return 16'd0;
    mag = x[15] ? 65536 - longint'(x) : longint'(x);
    num = mag * 32768;
    q   = num / longint'(m);
`ifdef NORM_ROUND_EN
    if (2 * (num % longint'(m)) >= longint'(m)) q++;
`endif
    if (q > 32767) q = 32767;
    if (x[15]) q = (65536 - q) % 65536;
    return 16'(q);
  endfunction

  // DMA responder: completes each write rdy_delay cycles after it is seen.
  always begin
    @(negedge clk);
    if (rst && dma_write) begin
      repeat (rdy_delay) @(negedge clk);
      dma_rdy = 1'b1;
      @(negedge clk);
      dma_rdy = 1'b0;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      if (spect_rdy) n_rdy++;
      if (done) begin
        n_done++;
        chk("busy_low_with_done", {63'd0, busy}, 64'd0);
      end
      if (dma_write) begin
        n_writes++;
        if (exp_q.size() == 0) chk("unexpected_write", {dma_addr, dma_writedata}, 64'd0);
        else chk("dma_write_addr_data", {dma_addr, dma_writedata}, exp_q.pop_front());
      end else if (dma_addr !== 32'd0 || dma_writedata !== 32'd0) begin
        chk("dma_idle_zero", {dma_addr, dma_writedata}, 64'd0);
      end
    end
  end

  // driver tasks
  task automatic send_pair(input logic [15:0] x1, input logic [15:0] x2, input logic [15:0] m);
    bit ok = 0;
    @(negedge clk);
    spect_data_1 = x1; spect_data_2 = x2; max = m; spect_valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      #1;
      if (spect_rdy) begin
        ok = 1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    spect_valid = 1'b0;
    if (!ok) chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic pulse_start(input logic [31:0] a0, input logic [31:0] a1);
    @(negedge clk);
    start = 1'b1; dst_start_addr = a0; dst_stop_addr = a1;
    @(negedge clk);
    start = 1'b0; dst_start_addr = '0; dst_stop_addr = '0;
  endtask

  task automatic run_block(input logic [31:0] a0, input int n, input int dly, input bit poke);
    int rdy0, done0;
    bit got = 0;
    rdy_delay = dly;
    rdy0 = n_rdy; done0 = n_done;
    for (int i = 0; i < n; i++) exp_q.push_back({a0 + 32'(4 * i), bexp[i]});
    pulse_start(a0, a0 + 32'(4 * (n - 1)));
    for (int i = 0; i < n; i++) begin
      send_pair(bx1[i], bx2[i], bmx[i]);
      if (poke && i == 0) pulse_start(32'hDEAD_0000, 32'hDEAD_0000);
    end
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      #1;
      if (n_done != done0) got = 1;
    end
    chk("block_done_seen", {63'd0, got}, 64'd1);
    repeat (2) @(negedge clk);
    chk("spect_rdy_pulses", 64'(n_rdy - rdy0), 64'(n));
    chk("done_pulses", 64'(n_done - done0), 64'd1);
    chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
    chk("busy_after_block", {63'd0, busy}, 64'd0);
    exp_q.delete();
  endtask

  initial begin
    tab[0] = '{16'h2000, 16'hE000, 16'h4000, 32'h4000_C000};
    tab[1] = '{16'h4000, 16'hC000, 16'h4000, 32'h7FFF_8001};
    tab[2] = '{16'h1234, 16'h8000, 16'h0000, 32'h0000_0000};
`ifdef NORM_ROUND_EN
    tab[3] = '{16'h0001, 16'h0000, 16'h0003, 32'h2AAB_0000};
`else
    tab[3] = '{16'h0001, 16'h0000, 16'h0003, 32'h2AAA_0000};
`endif
    tab[4] = '{16'h8000, 16'h0001, 16'h0001, 32'h8001_7FFF};
    tab[5] = '{16'h7FFF, 16'h8001, 16'h8000, 32'h7FFF_8001};

    // reset state
    #12;
    chk("reset_outputs", {dma_addr, dma_writedata}, 64'd0);
    chk("reset_flags", {60'd0, spect_rdy, dma_write, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // spect_valid ignored in IDLE
    @(negedge clk);
    spect_valid = 1'b1;
    #1;
    chk("idle_no_rdy", {63'd0, spect_rdy}, 64'd0);
    @(negedge clk);
    spect_valid = 1'b0;

    // table vectors, one pair per block with start == stop
    for (int i = 0; i < 6; i++) begin
      bx1[0] = tab[i].x1; bx2[0] = tab[i].x2; bmx[0] = tab[i].mx; bexp[0] = tab[i].exp;
      run_block(32'h100 + 32'(16 * i), 1, 1 + (i % 3), 0);
    end

    // three pairs, slow DMA, start pulse while busy
    for (int i = 0; i < 3; i++) begin
      bx1[i] = tab[i].x1; bx2[i] = tab[i].x2; bmx[i] = tab[i].mx; bexp[i] = tab[i].exp;
    end
    run_block(32'h0000_2000, 3, 5, 1);

    // address wrap-around
    for (int i = 0; i < 3; i++) begin
      bx1[i] = 16'(i * 300); bx2[i] = 16'hFF00; bmx[i] = 16'h7000;
      bexp[i] = {model_lane(bx1[i], bmx[i]), model_lane(bx2[i], bmx[i])};
    end
    run_block(32'hFFFF_FFFC, 3, 2, 0);

    // random blocks
    for (int b = 0; b < 8; b++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        int sel;
        sel = $urandom_range(0, 9);
        bx1[i] = 16'($urandom); bx2[i] = 16'($urandom);
        bmx[i] = (sel == 0) ? 16'd0 : (sel == 1) ? 16'($urandom_range(1, 8)) : 16'($urandom);
        bexp[i] = {model_lane(bx1[i], bmx[i]), model_lane(bx2[i], bmx[i])};
      end
      run_block(32'($urandom) & 32'hFFFF_FFFC, n, $urandom_range(1, 4), 0);
    end

    // reset in the middle of a division
    begin
      int w0;
      pulse_start(32'h500, 32'h500);
      send_pair(16'h2000, 16'h2000, 16'h4000);
      repeat (8) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_outputs", {dma_addr, dma_writedata}, 64'd0);
      chk("abort_flags", {60'd0, spect_rdy, dma_write, busy, done}, 64'd0);
      w0 = n_writes;
      @(negedge clk);
      rst = 1'b1;
      repeat (60) @(negedge clk);
      chk("no_write_after_abort", 64'(n_writes - w0), 64'd0);
      chk("idle_after_abort", {63'd0, busy}, 64'd0);
    end

    // recovery block
    bx1[0] = 16'h2000; bx2[0] = 16'hE000; bmx[0] = 16'h4000; bexp[0] = 32'h4000_C000;
    run_block(32'h600, 1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
